// File: rtl/pipeline_registers_set.sv
// rtl/pipeline_registers_set.sv - parameterizable shift-register pipeline with parallel load
module pipeline_registers_set #(
    parameter int BIT_WIDTH        = 32,
    parameter int NUMBER_OF_STAGES = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 set,
    // A zero-stage pipe has no load slices; keep the port one bit wide so the
    // declaration stays legal, it is ignored in that configuration.
    input  logic [((NUMBER_OF_STAGES > 0) ? BIT_WIDTH*NUMBER_OF_STAGES : 1)-1:0] set_data,
    input  logic [BIT_WIDTH-1:0] pipe_in,
    output logic [BIT_WIDTH-1:0] pipe_out
);

    generate
        if (NUMBER_OF_STAGES == 0) begin : g_bypass
            // No registers at all: the pipe degenerates to a wire.
            assign pipe_out = pipe_in;
        end else begin : g_pipe
            // stage[0] takes pipe_in; stage[NUMBER_OF_STAGES-1] drives pipe_out.
            logic [BIT_WIDTH-1:0] stage [NUMBER_OF_STAGES];

            // Stage update: async clear, then parallel load, otherwise shift by one.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 0; k < NUMBER_OF_STAGES; k++) begin
                        stage[k] <= '0;
                    end
                end else if (set) begin
                    for (int k = 0; k < NUMBER_OF_STAGES; k++) begin
                        stage[k] <= set_data[k*BIT_WIDTH +: BIT_WIDTH];
                    end
                end else begin
                    stage[0] <= pipe_in;
                    for (int k = 1; k < NUMBER_OF_STAGES; k++) begin
                        stage[k] <= stage[k-1];
                    end
                end
            end

            assign pipe_out = stage[NUMBER_OF_STAGES-1];
        end
    endgenerate

endmodule

// File: tb/tb_pipeline_registers_set.sv
// tb/tb_pipeline_registers_set.sv - scoreboard bench for pipeline_registers_set (8 bits, 4 stages)
module tb_pipeline_registers_set;

    localparam int BW = 8;
    localparam int NS = 4;

    logic          clk;
    logic          reset;
    logic          set;
    logic [BW*NS-1:0] set_data;
    logic [BW-1:0] din;
    logic          loop_en;
    logic [BW-1:0] pipe_in;
    logic [BW-1:0] pipe_out;

    int checks;
    int errors;

    // Future outputs after the current edge, oldest first (stages NS-2..0).
    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] cur;

    assign pipe_in = loop_en ? pipe_out : din;

    pipeline_registers_set #(
        .BIT_WIDTH       (BW),
        .NUMBER_OF_STAGES(NS)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .set     (set),
        .set_data(set_data),
        .pipe_in (pipe_in),
        .pipe_out(pipe_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock of stimulus: drive at negedge, push expectation, compare after the edge.
    task automatic step(input logic s, input logic lp, input logic [BW-1:0] v, input string tag);
        logic [BW-1:0] exp;
        @(negedge clk);
        set     = s;
        loop_en = lp;
        din     = v;
        if (s) begin
            exp   = set_data[31:24];
            exp_q = {set_data[23:16], set_data[15:8], set_data[7:0]};
        end else begin
            exp_q.push_back(lp ? cur : v);
            exp = exp_q.pop_front();
        end
        cur = exp;
        @(posedge clk);
        #1;
        check(tag, pipe_out, exp);
    endtask

    // Assert reset between clock edges and observe the output with no edge in between.
    task automatic reset_midcycle(input string tag);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check(tag, pipe_out, '0);
        exp_q = {8'h00, 8'h00, 8'h00};
        cur   = '0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        set      = 1'b0;
        loop_en  = 1'b0;
        din      = '0;
        set_data = {8'h67, 8'h45, 8'h23, 8'h01};
        exp_q    = {8'h00, 8'h00, 8'h00};
        cur      = '0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_init", pipe_out, '0);

        // Load, then an asynchronous reset mid-cycle
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 8'h00, "load_first");
        reset_midcycle("reset_async");

        // Reset dominates set
        @(negedge clk);
        set = 1'b1;
        @(posedge clk); #1; check("reset_over_set_0", pipe_out, '0);
        @(posedge clk); #1; check("reset_over_set_1", pipe_out, '0);
        @(negedge clk);
        reset = 1'b0;
        set   = 1'b0;

        // Load and ring rotation, two full periods
        step(1'b1, 1'b1, 8'h00, "load_ring");
        for (int i = 0; i < 2*NS; i++) begin
            step(1'b0, 1'b1, 8'h00, $sformatf("ring_%0d", i));
        end
        check("ring_period_back_to_top", cur, 8'h67);

        // Set wins over pipe_in = FF, then drain with zeros
        step(1'b1, 1'b0, 8'hFF, "set_priority");
        for (int i = 0; i < NS; i++) begin
            step(1'b0, 1'b0, 8'h00, $sformatf("drain_%0d", i));
        end

        // Delay line: single A5 pulse emerges NS clocks later, one cycle wide
        step(1'b0, 1'b0, 8'hA5, "delay_0");
        for (int i = 1; i < NS + 2; i++) begin
            step(1'b0, 1'b0, 8'h00, $sformatf("delay_%0d", i));
        end

        // Async reset during rotation, then ring of zeros after release
        step(1'b1, 1'b1, 8'h00, "load_again");
        step(1'b0, 1'b1, 8'h00, "rot_a");
        step(1'b0, 1'b1, 8'h00, "rot_b");
        reset_midcycle("reset_in_rotation");
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < NS + 1; i++) begin
            step(1'b0, 1'b1, 8'h00, $sformatf("zero_ring_%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
